// File: rtl/wb_write_queue.sv
// wb_write_queue: four-entry write-back queue that merges load results and
// ALU results into a single register-file write port.
// Load requests win when only one slot is free. Writes reach the register
// file in strict acceptance order, one per cycle, through registered
// WE3/A3/WD3 outputs.
module wb_write_queue #(
  parameter int DW    = 24,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [2:0]    mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          alu_valid,
  input  logic [2:0]    alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          flush,
  output logic          WE3,
  output logic [2:0]    A3,
  output logic [DW-1:0] WD3,
  output logic [7:0]    pend_mask,
  output logic [2:0]    fill
);

  logic [1:0]    rdPtr_q, rdPtr_d;
  logic [1:0]    wrPtr_q, wrPtr_d;
  logic [2:0]    fill_q, fill_d;
  logic          we_q, we_d;
  logic [2:0]    a3_q, a3_d;
  logic [DW-1:0] wd_q, wd_d;

  logic [2:0]    rdMem_q   [4];
  logic [DW-1:0] dataMem_q [4];

  logic          popNow;
  logic [3:0]    freeSlots;
  logic          memPush;
  logic          aluPush;
  logic [1:0]    memIdx;
  logic [1:0]    aluIdx;

  // Handshake: the pop that happens this cycle frees a slot before the pushes land.
  always_comb begin
    popNow    = (fill_q != 3'd0) && !flush;
    freeSlots = 4'(DEPTH) - {1'b0, fill_q} + {3'b000, popNow};
    mem_ready = rst && !flush && (freeSlots >= 4'd1);
    alu_ready = rst && !flush &&
                ((freeSlots >= 4'd2) || ((freeSlots >= 4'd1) && !mem_valid));
    memPush   = mem_valid && mem_ready && (mem_rd != 3'd0);
    aluPush   = alu_valid && alu_ready && (alu_rd != 3'd0);
    memIdx    = wrPtr_q;
    aluIdx    = wrPtr_q + {1'b0, memPush};
  end

  // Next state for the pointers, the occupancy count and the write port.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    fill_d  = fill_q;
    we_d    = 1'b0;
    a3_d    = a3_q;
    wd_d    = wd_q;
    if (flush) begin
      rdPtr_d = 2'd0;
      wrPtr_d = 2'd0;
      fill_d  = 3'd0;
    end else begin
      if (popNow) begin
        we_d    = 1'b1;
        a3_d    = rdMem_q[rdPtr_q];
        wd_d    = dataMem_q[rdPtr_q];
        rdPtr_d = rdPtr_q + 2'd1;
      end
      wrPtr_d = wrPtr_q + {1'b0, memPush} + {1'b0, aluPush};
      fill_d  = fill_q + {2'b00, memPush} + {2'b00, aluPush} - {2'b00, popNow};
    end
  end

  // Control registers; reset clears the queue and the write port at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr_q <= 2'd0;
      wrPtr_q <= 2'd0;
      fill_q  <= 3'd0;
      we_q    <= 1'b0;
      a3_q    <= 3'd0;
      wd_q    <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      fill_q  <= fill_d;
      we_q    <= we_d;
      a3_q    <= a3_d;
      wd_q    <= wd_d;
    end
  end

  // Entry storage; the load entry takes the first free slot, the ALU entry the next.
  always_ff @(posedge clk) begin
    if (memPush) begin
      rdMem_q[memIdx]   <= mem_rd;
      dataMem_q[memIdx] <= mem_data;
    end
    if (aluPush) begin
      rdMem_q[aluIdx]   <= alu_rd;
      dataMem_q[aluIdx] <= alu_data;
    end
  end

  // Pending mask: every live entry plus the write currently on the port.
  always_comb begin
    logic [1:0] offset;
    pend_mask = 8'h00;
    for (int i = 0; i < 4; i++) begin
      offset = 2'(i) - rdPtr_q;
      if ({1'b0, offset} < fill_q) begin
        pend_mask[rdMem_q[i]] = 1'b1;
      end
    end
    if (we_q) begin
      pend_mask[a3_q] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  assign WE3  = we_q;
  assign A3   = a3_q;
  assign WD3  = wd_q;
  assign fill = fill_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed test of the write-back queue.
// A queue-based reference model is checked against the DUT on every cycle.
// Literal expectations pin the key scenarios.
module tb_wb_write_queue;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid;
  logic [2:0]    mem_rd;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          alu_valid;
  logic [2:0]    alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          flush;
  logic          WE3;
  logic [2:0]    A3;
  logic [DW-1:0] WD3;
  logic [7:0]    pend_mask;
  logic [2:0]    fill;

  typedef struct {
    logic [2:0]    rd;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        modelQ[$];
  entry_t        headEntry;
  logic          expWe;
  logic [2:0]    expA3;
  logic [DW-1:0] expWd;
  int            expFill;
  int            expFree;
  logic          expMemRdy;
  logic          expAluRdy;
  logic [7:0]    expPend;
  logic          memAcc;
  logic          aluAcc;

  int checks = 0;
  int fails  = 0;

  wb_write_queue #(.DW(DW), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .flush     (flush),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .pend_mask (pend_mask),
    .fill      (fill)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic mv, input logic [2:0] mrd, input logic [DW-1:0] md,
                             input logic av, input logic [2:0] ard, input logic [DW-1:0] ad,
                             input logic fl);
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    flush     = fl;
  endtask

  // Drive on the falling edge and return just after the next rising edge.
  task automatic applyStimulus(input logic mv, input logic [2:0] mrd, input logic [DW-1:0] md,
                               input logic av, input logic [2:0] ard, input logic [DW-1:0] ad,
                               input logic fl);
    @(negedge clk);
    driveInputs(mv, mrd, md, av, ard, ad, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0);
  endtask

  task automatic modelReset();
    modelQ.delete();
    expWe = 1'b0;
    expA3 = 3'd0;
    expWd = '0;
  endtask

  // Expected outputs come from the model's queue contents and the current inputs.
  task automatic modelExpect();
    expFill   = modelQ.size();
    expFree   = 4 - expFill + (((expFill > 0) && !flush) ? 1 : 0);
    expMemRdy = rst && !flush && (expFree >= 1);
    expAluRdy = rst && !flush && ((expFree >= 2) || ((expFree >= 1) && !mem_valid));
    expPend   = 8'h00;
    foreach (modelQ[k]) expPend[modelQ[k].rd] = 1'b1;
    if (expWe) expPend[expA3] = 1'b1;
    expPend[0] = 1'b0;
  endtask

  // Compare process: check late in the low phase, then advance the model on the edge.
  initial begin
    modelReset();
    forever begin
      @(negedge clk);
      #3;
      if (!rst) modelReset();
      modelExpect();
      checkOutput("fill",      32'(fill),      32'(expFill));
      checkOutput("mem_ready", 32'(mem_ready), 32'(expMemRdy));
      checkOutput("alu_ready", 32'(alu_ready), 32'(expAluRdy));
      checkOutput("WE3",       32'(WE3),       32'(expWe));
      checkOutput("A3",        32'(A3),        32'(expA3));
      checkOutput("WD3",       32'(WD3),       32'(expWd));
      checkOutput("pend_mask", 32'(pend_mask), 32'(expPend));
      @(posedge clk);
      if (!rst) begin
        modelReset();
      end else if (flush) begin
        modelQ.delete();
        expWe = 1'b0;
      end else begin
        modelExpect();
        memAcc = mem_valid && expMemRdy;
        aluAcc = alu_valid && expAluRdy;
        if (modelQ.size() > 0) begin
          headEntry = modelQ.pop_front();
          expWe = 1'b1;
          expA3 = headEntry.rd;
          expWd = headEntry.data;
        end else begin
          expWe = 1'b0;
        end
        if (memAcc && (mem_rd != 3'd0)) modelQ.push_back('{mem_rd, mem_data});
        if (aluAcc && (alu_rd != 3'd0)) modelQ.push_back('{alu_rd, alu_data});
      end
    end
  end

  // Directed scenarios with literal expectations.
  initial begin
    rst = 1'b1;
    driveInputs(1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstWE3",      32'(WE3),       32'h0);
    checkOutput("rstFill",     32'(fill),      32'h0);
    checkOutput("rstPend",     32'(pend_mask), 32'h0);
    checkOutput("rstMemReady", 32'(mem_ready), 32'h0);

    // Single load to r5, accepted on the first edge after reset release.
    @(negedge clk);
    rst = 1'b1;
    driveInputs(1'b1, 3'd5, 24'h00ABCD, 1'b0, 3'd0, '0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("singleFillE",  32'(fill),      32'h1);
    checkOutput("singlePendE",  32'(pend_mask), 32'h20);
    checkOutput("singleWeE",    32'(WE3),       32'h0);
    idle();
    checkOutput("singleWe",     32'(WE3),       32'h1);
    checkOutput("singleA3",     32'(A3),        32'h5);
    checkOutput("singleWD3",    32'(WD3),       32'h00ABCD);
    checkOutput("singlePendE1", 32'(pend_mask), 32'h20);
    idle();
    checkOutput("singleWeOff",  32'(WE3),       32'h0);
    checkOutput("singlePendE2", 32'(pend_mask), 32'h00);

    // Simultaneous load (r2) and ALU (r3): load is written first.
    applyStimulus(1'b1, 3'd2, 24'h111111, 1'b1, 3'd3, 24'h222222, 1'b0);
    checkOutput("dualFill", 32'(fill),      32'h2);
    checkOutput("dualPend", 32'(pend_mask), 32'h0C);
    idle();
    checkOutput("dualFirstA3",  32'(A3),  32'h2);
    checkOutput("dualFirstWD3", 32'(WD3), 32'h111111);
    idle();
    checkOutput("dualSecondWe",  32'(WE3), 32'h1);
    checkOutput("dualSecondA3",  32'(A3),  32'h3);
    checkOutput("dualSecondWD3", 32'(WD3), 32'h222222);
    idle();
    checkOutput("dualDone", 32'(WE3), 32'h0);

    // Six back-to-back dual requests: the queue saturates and the ALU path backs off.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      driveInputs(1'b1, 3'(i + 1), DW'(24'h100000 + i),
                  1'b1, 3'(((i + 3) % 7) + 1), DW'(24'h200000 + i), 1'b0);
      #1;
      if (i >= 3) begin
        checkOutput("fullAluReady", 32'(alu_ready), 32'h0);
        checkOutput("fullMemReady", 32'(mem_ready), 32'h1);
      end
      @(posedge clk);
      #1;
      if (i == 2) checkOutput("fullFill", 32'(fill), 32'h4);
    end
    checkOutput("fullFillEnd", 32'(fill), 32'h4);
    repeat (6) idle();
    checkOutput("drainFill", 32'(fill), 32'h0);
    checkOutput("drainWe",   32'(WE3),  32'h0);

    // ALU write to r0 is accepted but discarded.
    applyStimulus(1'b0, 3'd0, '0, 1'b1, 3'd0, 24'hDEAD00, 1'b0);
    checkOutput("r0Fill", 32'(fill), 32'h0);
    idle();
    checkOutput("r0We",   32'(WE3),  32'h0);

    // Flush with three entries queued and a load pending.
    applyStimulus(1'b1, 3'd1, 24'h000001, 1'b1, 3'd2, 24'h000002, 1'b0);
    applyStimulus(1'b1, 3'd3, 24'h000003, 1'b1, 3'd4, 24'h000004, 1'b0);
    checkOutput("preFlushFill", 32'(fill), 32'h3);
    @(negedge clk);
    driveInputs(1'b1, 3'd5, 24'h000005, 1'b0, 3'd0, '0, 1'b1);
    #1;
    checkOutput("flushMemReady", 32'(mem_ready), 32'h0);
    checkOutput("flushWePulse",  32'(WE3),       32'h1);
    @(posedge clk);
    #1;
    checkOutput("flushFill", 32'(fill),      32'h0);
    checkOutput("flushWe",   32'(WE3),       32'h0);
    checkOutput("flushPend", 32'(pend_mask), 32'h0);
    idle();
    checkOutput("postFlushWe",   32'(WE3),  32'h0);
    checkOutput("postFlushFill", 32'(fill), 32'h0);

    // Asynchronous reset between edges while two writes are queued.
    applyStimulus(1'b1, 3'd6, 24'h000006, 1'b1, 3'd7, 24'h000007, 1'b0);
    applyStimulus(1'b1, 3'd5, 24'h000055, 1'b0, 3'd0, '0, 1'b0);
    checkOutput("preRstFill", 32'(fill),      32'h2);
    checkOutput("preRstPend", 32'(pend_mask), 32'hE0);
    #1 rst = 1'b0;
    #1;
    checkOutput("asyncRstFill", 32'(fill),      32'h0);
    checkOutput("asyncRstWe",   32'(WE3),       32'h0);
    checkOutput("asyncRstPend", 32'(pend_mask), 32'h0);
    checkOutput("asyncRstA3",   32'(A3),        32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    driveInputs(1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0);

    // Operation resumes normally after reset.
    applyStimulus(1'b1, 3'd1, 24'h0F0F0F, 1'b0, 3'd0, '0, 1'b0);
    idle();
    checkOutput("resumeWe",  32'(WE3), 32'h1);
    checkOutput("resumeA3",  32'(A3),  32'h1);
    checkOutput("resumeWD3", 32'(WD3), 32'h0F0F0F);
    repeat (3) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
Parameters:
REQ-001 The block SHALL have parameter DW, default 24, meaning the register data width, matched to the register file storage width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries; the only supported value is 4.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port mem_valid, input, 1 bit: load-result write request.
REQ-006 The block SHALL have port mem_rd, input, 3 bits: load-result destination register.
REQ-007 The block SHALL have port mem_data, input, DW bits: load-result data.
REQ-008 The block SHALL have port mem_ready, output, 1 bit: the load request is accepted this cycle.
REQ-009 The block SHALL have ports alu_valid (input, 1), alu_rd (input, 3), alu_data (input, DW) and alu_ready (output, 1): the ALU-result request, same semantics as the mem_* ports.
REQ-010 The block SHALL have port flush, input, 1 bit: synchronous queue clear.
REQ-011 The block SHALL have port WE3, output, 1 bit, registered: the register-file write enable.
REQ-012 The block SHALL have port A3, output, 3 bits, registered: the register-file write address.
REQ-013 The block SHALL have port WD3, output, DW bits, registered: the register-file write data.
REQ-014 The block SHALL have port pend_mask, output, 8 bits: bit r=1 when a write to register r is queued or presented on WE3/A3.
REQ-015 The block SHALL have port fill, output, 3 bits: the number of valid queue entries, 0..4.

Function
REQ-016 A request SHALL be accepted on a rising edge when its valid and ready are both 1; an accepted request with rd=0 SHALL be discarded and not enqueued.
REQ-017 mem_ready SHALL be 1 when free>=1, where free = DEPTH - fill + (1 if a pop occurs this cycle).
REQ-018 alu_ready SHALL be 1 when free>=2, or when free>=1 and mem_valid=0; the load path therefore has priority.
REQ-019 When both requests are accepted in the same cycle, the mem entry SHALL be enqueued ahead of the alu entry.
REQ-020 The block SHALL pop exactly one entry per cycle whenever fill>0 at the rising edge, loading A3/WD3 from the head and setting WE3=1; when fill=0, WE3 SHALL be 0 and A3/WD3 SHALL hold their values.
REQ-021 Latency SHALL be: a request accepted at edge E into an empty queue gives WE3=1 after edge E+1, and the register file writes at E+2; there SHALL be no bypass path from the inputs to WE3.
REQ-022 Push and pop in the same cycle SHALL be legal; when full with a pop, up to one new entry SHALL be accepted.
REQ-023 The queue SHALL be a circular buffer with 2-bit read/write pointers wrapping 3->0; fill SHALL never exceed 4 and SHALL never underflow.
REQ-024 pend_mask SHALL be combinational: the OR over valid entries of onehot(rd), ORed with onehot(A3) when WE3=1; bit 0 SHALL always be 0; duplicate rd entries keep the bit set until the last one has drained.
REQ-025 When flush=1 at an edge, the block SHALL set fill=0, reset both pointers to 0, drop same-cycle requests (ready=0 while flush=1) and set WE3=0; a WE3 pulse already on the output SHALL complete in that cycle.
REQ-026 Queue order SHALL be strict FIFO: register-file writes occur in acceptance order.

Reset
REQ-027 When rst=0 (asynchronous), the block SHALL set WE3=0, A3=0, WD3=0, fill=0, both pointers to 0 and pend_mask=0; mem_ready and alu_ready SHALL be 0 while rst=0.
REQ-028 When rst is asserted mid-operation, all queued writes SHALL be lost; after release the first accept SHALL be possible on the first rising edge.

Verification
REQ-029 The bench SHALL cover: single mem_valid, rd=5, data=0x00ABCD at edge E -> WE3=1, A3=5, WD3=0x00ABCD after E+1; pend_mask=0x20 from E to E+2.
REQ-030 The bench SHALL cover: mem and alu valid at once (rd=2, rd=3) into an empty queue -> both accepted; writes to A3=2 then A3=3 on consecutive cycles.
REQ-031 The bench SHALL cover: fill=4 with no pop (held by flush-free stall not possible) -> drive 6 back-to-back dual requests -> fill never >4, alu_ready=0 whenever free=1 and mem_valid=1, output order equals acceptance order.
REQ-032 The bench SHALL cover: alu_valid with rd=0 -> accepted, fill unchanged, no WE3.
REQ-033 The bench SHALL cover: queue holding 3 entries, flush=1 with mem_valid=1 -> fill=0, mem_ready=0, WE3=0 on the following cycle.
REQ-034 The bench SHALL cover: rst=0 asserted between edges while fill=2 -> WE3, fill and pend_mask go to 0 immediately without a clock edge.
